// File: rtl/vote_tally_pkg.sv
// ---------------------------------------------------------------------------
// vote_tally_pkg
// Shared types and helpers for the vote_tally ballot block.
//   state_t : ballot FSM state encoding (IDLE -> COLLECT -> DONE -> IDLE)
//   cnt_w() : width needed to hold a tally of 0..n yes votes
// Optional feature macro used by the top level: VOTE_TALLY_VETO_EN.
// ---------------------------------------------------------------------------
package vote_tally_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// ---------------------------------------------------------------------------
// vote_popcount
// Purely combinational population count of an N-bit vector.
// Ports:
//   i_vec    in   N       vector to count
//   o_count  out  CNT_W   number of ones in i_vec
// ---------------------------------------------------------------------------
module vote_popcount
    import vote_tally_pkg::*;
#(
    parameter int N = 5,
    localparam int CNT_W = cnt_w(N)
) (
    input  logic [N-1:0]     i_vec,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] w_count;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N; i++) begin
            w_count = w_count + CNT_W'(i_vec[i]);
        end
    end

    assign o_count = w_count;

endmodule

// File: rtl/vote_tally.sv
// ---------------------------------------------------------------------------
// vote_tally
// Timed ballot over N_VOTERS level inputs. Each voter's first "yes" is
// latched into a sticky mask; the ballot closes as soon as the outcome is
// settled (threshold reached, everyone voted) or the window expires.
// Optional feature macro: VOTE_TALLY_VETO_EN -- when defined, votes[0] is
// the chair and no pass is possible without the chair's yes.
// Ports:
//   clk        in   1         system clock, rising edge
//   rst_n      in   1         synchronous reset, active low
//   start      in   1         opens a ballot; sampled only in IDLE
//   votes      in   N_VOTERS  per-voter yes level; votes[0] is the chair
//   busy       out  1         high while collecting
//   done       out  1         one-cycle pulse when the result becomes valid
//   pass       out  1         ballot result; held until the next start
//   yes_count  out  CNT_W     final tally; held until the next start
//   ballot     out  N_VOTERS  sticky yes mask; held until the next start
// ---------------------------------------------------------------------------
module vote_tally
    import vote_tally_pkg::*;
#(
    parameter int N_VOTERS  = 5,
    parameter int THRESHOLD = 3,
    parameter int WINDOW    = 16,
    localparam int CNT_W    = cnt_w(N_VOTERS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] votes,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    yes_count,
    output logic [N_VOTERS-1:0] ballot
);

    // A one-cycle window needs no countdown bits, but keep the timer at
    // least one bit wide so it stays a legal vector.
    localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0]    TIMER_LOAD = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] THR        = CNT_W'(THRESHOLD);

    state_t              r_state;
    logic [TW-1:0]       r_timer;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [CNT_W-1:0]    r_yes_count;
    logic [N_VOTERS-1:0] r_ballot;

    logic [N_VOTERS-1:0] w_bal_nx;
    logic [CNT_W-1:0]    w_tally;
    logic                w_chair_ok;
    logic                w_meets;
    logic                w_decide;

    // Mask as it will look after this edge; the decision is taken on it so
    // a vote arriving in the deciding cycle is already counted.
    assign w_bal_nx = r_ballot | votes;

    vote_popcount #(.N(N_VOTERS)) u_popcount (
        .i_vec   (w_bal_nx),
        .o_count (w_tally)
    );

`ifdef VOTE_TALLY_VETO_EN
    assign w_chair_ok = w_bal_nx[0];
`else
    assign w_chair_ok = 1'b1;
`endif

    assign w_meets  = (w_tally >= THR) && w_chair_ok;
    // Once everyone has voted nothing can change, so close early.
    assign w_decide = w_meets || (r_timer == '0) || (&w_bal_nx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_yes_count <= '0;
            r_ballot    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ballot    <= '0;
                        r_pass      <= 1'b0;
                        r_yes_count <= '0;
                        r_timer     <= TIMER_LOAD;
                        r_busy      <= 1'b1;
                        r_state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    r_ballot <= w_bal_nx;
                    if (w_decide) begin
                        r_pass      <= w_meets;
                        r_yes_count <= w_tally;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign yes_count = r_yes_count;
    assign ballot    = r_ballot;

endmodule

// File: tb/tb_vote_tally.sv
// ---------------------------------------------------------------------------
// tb_vote_tally
// Self-checking bench for vote_tally with N_VOTERS=5, THRESHOLD=3, WINDOW=8.
// Expected results come from a ballot model that replays the per-cycle vote
// sequence with plain set/count arithmetic.
// ---------------------------------------------------------------------------
module tb_vote_tally;

    localparam int N = 5;
    localparam int T = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] votes = '0;
    logic         busy;
    logic         done;
    logic         pass;
    logic [2:0]   yes_count;
    logic [N-1:0] ballot;

    int n_checks = 0;
    int n_fail   = 0;

    // Vote vector presented in COLLECT cycle c, and start pulses injected there.
    logic [N-1:0] stim     [1:W];
    logic         st_pulse [1:W];

    vote_tally #(.N_VOTERS(N), .THRESHOLD(T), .WINDOW(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .votes     (votes),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .yes_count (yes_count),
        .ballot    (ballot)
    );

    always #5 clk = ~clk;

    function automatic bit chair_ok(input logic [N-1:0] m);
`ifdef VOTE_TALLY_VETO_EN
        return m[0];
`else
        return 1'b1;
`endif
    endfunction

    // Ballot model: k = COLLECT cycle in which the outcome is decided.
    task automatic model(output int k, output logic p, output logic [2:0] cnt,
                         output logic [N-1:0] m);
        m = '0; k = W; p = 1'b0; cnt = '0;
        for (int c = 1; c <= W; c++) begin
            m   = m | stim[c];
            cnt = 3'($countones(m));
            p   = (int'(cnt) >= T) && chair_ok(m);
            if (p || (m == '1) || c == W) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic clear_stim();
        for (int c = 1; c <= W; c++) begin
            stim[c] = '0;
            st_pulse[c] = 1'b0;
        end
    endtask

    task automatic run_ballot(input string name, input bit start_in_done);
        int           exp_k;
        logic         exp_p;
        logic [2:0]   exp_c;
        logic [N-1:0] exp_m;
        int           got;
        model(exp_k, exp_p, exp_c, exp_m);
        @(negedge clk);
        start = 1'b1;
        votes = N'($urandom);          // ignored while IDLE
        @(posedge clk);
        got = 0;
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            votes = '0;
            if (done) begin
                got = c;
                break;
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy c%0d: got %b expected 1", name, c, busy);
            end
            if (c == 1) begin
                n_checks++;
                if ({pass, yes_count, ballot} !== '0) begin
                    n_fail++;
                    $display("FAIL %s cleared_on_start: got pass=%b cnt=%0d ballot=%b expected all 0",
                             name, pass, yes_count, ballot);
                end
            end
            if (c <= W) begin
                votes = stim[c];
                start = st_pulse[c];
            end
        end
        n_checks++;
        if (got != exp_k + 1) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, got, exp_k + 1);
        end
        n_checks++;
        if (busy !== 1'b0 || pass !== exp_p || yes_count !== exp_c || ballot !== exp_m) begin
            n_fail++;
            $display("FAIL %s result: got busy=%b pass=%b cnt=%0d ballot=%b expected busy=0 pass=%b cnt=%0d ballot=%b",
                     name, busy, pass, yes_count, ballot, exp_p, exp_c, exp_m);
        end
        start = start_in_done;
        @(negedge clk);
        start = 1'b0;
        votes = N'($urandom);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_p || yes_count !== exp_c || ballot !== exp_m) begin
            n_fail++;
            $display("FAIL %s idle_after: got done=%b busy=%b pass=%b cnt=%0d ballot=%b expected done=0 busy=0 pass=%b cnt=%0d ballot=%b",
                     name, done, busy, pass, yes_count, ballot, exp_p, exp_c, exp_m);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ballot !== exp_m) begin
            n_fail++;
            $display("FAIL %s idle_hold: got busy=%b ballot=%b expected busy=0 ballot=%b",
                     name, busy, ballot, exp_m);
        end
        votes = '0;
        $display("ballot %-14s done_cycle=%0d pass=%b yes_count=%0d ballot=%b", name, got, pass, yes_count, ballot);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, pass, yes_count, ballot} !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got busy=%b done=%b pass=%b cnt=%0d ballot=%b expected all 0",
                     busy, done, pass, yes_count, ballot);
        end
        rst_n = 1'b1;
        // Open a ballot, accumulate one vote, then reset mid-COLLECT.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        votes = 5'b00001;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || ballot !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_precond: got busy=%b ballot=%b expected busy=1 ballot=00001", busy, ballot);
        end
        rst_n = 1'b0;
        votes = 5'b11111;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, pass, yes_count, ballot} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_collect: got busy=%b done=%b pass=%b cnt=%0d ballot=%b expected all 0",
                     busy, done, pass, yes_count, ballot);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, ballot} !== '0) begin
            n_fail++;
            $display("FAIL reset_then_idle: got busy=%b done=%b ballot=%b expected all 0", busy, done, ballot);
        end
        votes = '0;
        $display("reset check complete");
    endtask

    task automatic test_early_pass();
        clear_stim();
        stim[1] = 5'b00111;
        run_ballot("early_pass", 1'b0);
    endtask

    task automatic test_timeout();
        clear_stim();
        for (int c = 1; c <= W; c++) stim[c] = 5'b00011;
        run_ballot("timeout", 1'b0);
    endtask

    task automatic test_pulses();
        clear_stim();
        stim[1] = 5'b00010;
        stim[3] = 5'b00100;
        stim[5] = 5'b10000;
        run_ballot("sticky_pulses", 1'b0);
    endtask

    task automatic test_chair();
        clear_stim();
        for (int c = 1; c <= W; c++) stim[c] = 5'b11110;
        run_ballot("chair_absent", 1'b0);
    endtask

    task automatic test_all_ones();
        clear_stim();
        stim[2] = 5'b11111;
        run_ballot("all_ones", 1'b0);
    endtask

    task automatic test_start_ignored();
        clear_stim();
        for (int c = 1; c <= W; c++) stim[c] = 5'b00011;
        st_pulse[2] = 1'b1;
        st_pulse[5] = 1'b1;
        run_ballot("start_ignored", 1'b1);
        // Following ballot must begin from a cleared result.
        clear_stim();
        stim[1] = 5'b01101;
        run_ballot("after_restart", 1'b0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 30; b++) begin
            for (int c = 1; c <= W; c++) begin
                stim[c]     = N'($urandom) & N'($urandom) & N'($urandom);
                st_pulse[c] = ($urandom_range(0, 3) == 0);
            end
            run_ballot($sformatf("random_%0d", b), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_early_pass();
        test_timeout();
        test_pulses();
        test_chair();
        test_all_ones();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
